fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the decoder. It holds the program counter and issues word reads to instruction memory over a request/response handshake. It registers each returned 32-bit instruction word with its PC into the IF/ID register, which the decoder slices into op/rd/ra/rb/offset fields. It also supports downstream stall and branch/exception redirect with flush of in-flight fetches.

---
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem request FSM, IF/ID register with 1-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc
);
  typedef enum logic [1:0] {REQ, WAIT, FULL} state_t;
  state_t      state;
  logic [31:0] pc, pend_pc, buf_data, buf_pc;
  logic        drop, hs, can_load;
  assign imem_req  = rst_n && state == REQ;
  assign imem_addr = pc;
  assign hs        = imem_req & imem_ready;
  assign can_load  = ~ir_valid | ~stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      pc       <= RESET_PC;
      pend_pc  <= '0;
      buf_data <= '0;
      buf_pc   <= '0;
      drop     <= 1'b0;
      ir_valid <= 1'b0;
      ir       <= '0;
      ir_pc    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~32'h3;
      ir_valid <= 1'b0;
      if (state == REQ) begin
        if (hs) begin
          drop  <= 1'b1;
          state <= WAIT;
        end
      end else if (state == WAIT) begin
        drop <= ~imem_rvalid;
        if (imem_rvalid) state <= REQ;
      end else begin
        state <= REQ;
      end
    end else begin
      if (ir_valid && !stall) ir_valid <= 1'b0;
      unique case (state)
        REQ: if (hs) begin
          pend_pc <= pc;
          pc      <= pc + 32'(PC_STEP);
          state   <= WAIT;
        end
        WAIT: if (imem_rvalid) begin
          state <= REQ;
          if (drop) begin
            drop <= 1'b0;
          end else if (can_load) begin
            ir       <= imem_rdata;
            ir_pc    <= pend_pc;
            ir_valid <= 1'b1;
          end else begin
            buf_data <= imem_rdata;
            buf_pc   <= pend_pc;
            state    <= FULL;
          end
        end
        FULL: if (!stall) begin
          ir       <= buf_data;
          ir_pc    <= buf_pc;
          ir_valid <= 1'b1;
          state    <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end
  // Memory may only answer while a request is outstanding.
  a_rvalid_in_wait: assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> state == WAIT);
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against hand-computed fetch/IF-ID sequences.
module tb_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid, stall, ir_valid;
  logic [31:0] redirect_pc, ir, ir_pc;
  logic        req2, rvalid2, ir_valid2;
  logic [31:0] addr2, rdata2, ir2, ir_pc2;
  int          n_checks = 0, n_err = 0;
  int          lat, cnt, n1 = 0, n2 = 0;
  logic        busy;
  logic [31:0] paddr;
  logic [31:0] log1 [8];
  logic [31:0] log2 [8];
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(1'b1), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .stall(1'b0),
    .ir_valid(ir_valid2), .ir(ir2), .ir_pc(ir_pc2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // One clock with the memory models: responses come lat cycles after the handshake.
  task automatic step();
    logic        hs, hs2;
    logic [31:0] a, a2;
    hs = imem_req & imem_ready;
    a  = imem_addr;
    hs2 = req2;
    a2  = addr2;
    if (hs && n1 < 8) begin log1[n1] = a; n1++; end
    if (hs2 && n2 < 8) begin log2[n2] = a2; n2++; end
    @(posedge clk); #1;
    if (imem_rvalid) begin
      imem_rvalid = 1'b0;
      busy = 1'b0;
    end else if (busy && cnt > 0) cnt--;
    if (hs) begin
      busy  = 1'b1;
      cnt   = lat - 1;
      paddr = a;
    end
    if (busy && cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = paddr ^ K;
    end
    rvalid2 = hs2;
    rdata2  = a2 ^ K;
  endtask
  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    rvalid2 = 1'b0; rdata2 = '0; busy = 1'b0; cnt = 0; paddr = '0; lat = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    check("rst_ir", ir, 32'h0);
    check("rst_ir_pc", ir_pc, 32'h0);
    check("rst_req2", {31'b0, req2}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("t1_req", {31'b0, imem_req}, 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t6_addr0", addr2, 32'hFFFF_FFF8);
    step();
    check("t1_lat_n1", {31'b0, ir_valid}, 32'd0);
    step();
    check("t1_lat_n2", {31'b0, ir_valid}, 32'd1);
    check("t1_ir0", ir, 32'hA5A5_0000);
    check("t1_pc0", ir_pc, 32'h0);
    check("t6_ir_valid", {31'b0, ir_valid2}, 32'd1);
    check("t6_ir", ir2, 32'h5A5A_FFF8);
    check("t6_ir_pc", ir_pc2, 32'hFFFF_FFF8);
    step();
    check("t1_consumed", {31'b0, ir_valid}, 32'd0);
    step();
    check("t1_ir1", ir, 32'hA5A5_0004);
    check("t1_pc1", ir_pc, 32'h4);
    check("t1_addr2", imem_addr, 32'h8);
    // Test 2: stall while pc=4 sits in IF/ID
    stall = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_hold_pc", ir_pc, 32'h4);
      check("t2_hold_valid", {31'b0, ir_valid}, 32'd1);
      check("t2_no_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("t2_ir", ir, 32'hA5A5_0008);
    check("t2_pc", ir_pc, 32'h8);
    check("t2_valid", {31'b0, ir_valid}, 32'd1);
    check("t2_addr12", imem_addr, 32'hC);
    check("t1_log0", log1[0], 32'h0);
    check("t1_log1", log1[1], 32'h4);
    check("t1_log2", log1[2], 32'h8);
    check("t6_log0", log2[0], 32'hFFFF_FFF8);
    check("t6_log1", log2[1], 32'hFFFF_FFFC);
    check("t6_log2", log2[2], 32'h0);
    // Test 3: redirect while waiting on a slow response
    lat = 3;
    step();
    check("t3_wait_req", {31'b0, imem_req}, 32'd0);
    check("t3_consumed", {31'b0, ir_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    check("t3_new_pc", imem_addr, 32'h100);
    check("t3_still_wait", {31'b0, imem_req}, 32'd0);
    step();
    step();
    check("t3_req", {31'b0, imem_req}, 32'd1);
    check("t3_addr", imem_addr, 32'h100);
    check("t3_dropped", {31'b0, ir_valid}, 32'd0);
    lat = 1;
    step();
    step();
    check("t3_ir", ir, 32'hA5A5_0100);
    check("t3_ir_pc", ir_pc, 32'h100);
    check("t3_valid", {31'b0, ir_valid}, 32'd1);
    // Test 4: redirect coinciding with a handshake, then a slow ready
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0; imem_ready = 1'b0;
    check("t4_flush", {31'b0, ir_valid}, 32'd0);
    check("t4_addr", imem_addr, 32'h200);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_req", {31'b0, imem_req}, 32'd1);
      check("t4_hold_addr", imem_addr, 32'h200);
      check("t4_no_stale", {31'b0, ir_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    step();
    check("t4_no_stale2", {31'b0, ir_valid}, 32'd0);
    step();
    check("t4_ir", ir, 32'hA5A5_0200);
    check("t4_ir_pc", ir_pc, 32'h200);
    // Test 5: async reset in WAIT with stall
    lat = 3; stall = 1'b1;
    step();
    check("t5_in_wait", {31'b0, imem_req}, 32'd0);
    check("t5_held", {31'b0, ir_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'b0, ir_valid}, 32'd0);
    check("t5_rst_ir", ir, 32'h0);
    check("t5_rst_ir_pc", ir_pc, 32'h0);
    check("t5_rst_req", {31'b0, imem_req}, 32'd0);
    check("t5_rst_addr", imem_addr, 32'h0);
    busy = 1'b0; imem_rvalid = 1'b0; rvalid2 = 1'b0; cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; stall = 1'b0; lat = 1;
    #1;
    check("t5_req", {31'b0, imem_req}, 32'd1);
    check("t5_addr", imem_addr, 32'h0);
    step();
    step();
    check("t5_ir", ir, 32'hA5A5_0000);
    check("t5_ir_pc", ir_pc, 32'h0);
    check("t5_valid", {31'b0, ir_valid}, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
